// File: rtl/ram_usage_monitor_pkg.sv
// Shared types and constants for the RAM usage monitor: FSM encoding,
// bank count and default datapath widths.
package ram_usage_monitor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NBANKS      = 2;
    localparam int BYTES_W_DEF = 16;
    localparam int OCC_W_DEF   = 64;
    localparam int CNT_W       = 32;

    // Last cycle of a window; a zero count is treated as last so a stray
    // zero can never leave the FSM stuck in RUN.
    function automatic logic window_last(input logic [CNT_W-1:0] remaining);
        window_last = (remaining <= 32'd1);
    endfunction

endpackage

// File: rtl/ram_usage_monitor_bank.sv
// One RAM bank's occupancy tracker: saturating occupancy, sticky underflow
// and high-water mark, all cleared together when a new window starts.
module usage_bank
    import ram_usage_monitor_pkg::*;
#(
    parameter int BYTES_W = BYTES_W_DEF,
    parameter int OCC_W   = OCC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               alloc_valid,
    input  logic [BYTES_W-1:0] alloc_bytes,
    input  logic               free_valid,
    input  logic [BYTES_W-1:0] free_bytes,
    output logic [OCC_W-1:0]   hwm,
    output logic               underflow
);

    localparam int SUM_W = OCC_W + 1;

    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] hwm_r;
    logic             underflow_r;
    logic [SUM_W-1:0] add_s;
    logic [SUM_W-1:0] sub_s;
    logic [OCC_W:0]   upd_s;
    logic [OCC_W-1:0] occ_next_s;
    logic             uflow_s;

    // Returns {underflow, next occupancy}; clamps to zero or to all-ones.
    function automatic logic [OCC_W:0] occ_update(
        input logic [OCC_W-1:0] occ,
        input logic [SUM_W-1:0] add,
        input logic [SUM_W-1:0] sub
    );
        logic [SUM_W-1:0] up;
        logic [SUM_W-1:0] diff;
        up   = {1'b0, occ} + add;
        diff = {SUM_W{1'b0}};
        if (sub > up) begin
            occ_update = {1'b1, {OCC_W{1'b0}}};
        end else begin
            diff = up - sub;
            if (diff[OCC_W]) begin
                occ_update = {1'b0, {OCC_W{1'b1}}};
            end else begin
                occ_update = {1'b0, diff[OCC_W-1:0]};
            end
        end
    endfunction

    // Next-occupancy datapath for this cycle's alloc/free pair.
    always_comb begin
        add_s      = alloc_valid ? SUM_W'(alloc_bytes) : {SUM_W{1'b0}};
        sub_s      = free_valid  ? SUM_W'(free_bytes)  : {SUM_W{1'b0}};
        upd_s      = occ_update(occ_r, add_s, sub_s);
        occ_next_s = upd_s[OCC_W-1:0];
        uflow_s    = upd_s[OCC_W];
    end

    // Occupancy, peak and sticky underflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r       <= {OCC_W{1'b0}};
            hwm_r       <= {OCC_W{1'b0}};
            underflow_r <= 1'b0;
        end else if (clear) begin
            occ_r       <= {OCC_W{1'b0}};
            hwm_r       <= {OCC_W{1'b0}};
            underflow_r <= 1'b0;
        end else if (enable) begin
            occ_r       <= occ_next_s;
            hwm_r       <= (occ_next_s > hwm_r) ? occ_next_s : hwm_r;
            underflow_r <= underflow_r | uflow_s;
        end else begin
            occ_r       <= occ_r;
            hwm_r       <= hwm_r;
            underflow_r <= underflow_r;
        end
    end

    assign hwm       = hwm_r;
    assign underflow = underflow_r;

endmodule

// File: rtl/ram_usage_monitor.sv
// Measurement-window controller: opens a window of cycle_count clocks on
// start and tracks per-bank RAM occupancy peaks while it is open.
module ram_usage_monitor
    import ram_usage_monitor_pkg::*;
#(
    parameter int BYTES_W = BYTES_W_DEF,
    parameter int OCC_W   = OCC_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CNT_W-1:0]      cycle_count,
    input  logic                  start,
    input  logic [NBANKS-1:0]     alloc_valid,
    input  logic [2*BYTES_W-1:0]  alloc_bytes,
    input  logic [NBANKS-1:0]     free_valid,
    input  logic [2*BYTES_W-1:0]  free_bytes,
    output logic [OCC_W-1:0]      hwm_0,
    output logic [OCC_W-1:0]      hwm_1,
    output logic                  busy,
    output logic                  done,
    output logic [NBANKS-1:0]     underflow
);

    state_t           state_r;
    logic [CNT_W-1:0] remaining_r;
    logic             busy_r;
    logic             done_r;
    logic             last_s;
    logic             zero_len_s;
    logic             enable_s;
    logic [OCC_W-1:0] hwm_s [NBANKS];
    logic [NBANKS-1:0] uflow_s;

    // Window-close and event-acceptance qualifiers; start-cycle events are dropped.
    always_comb begin
        last_s     = (state_r == RUN) && window_last(remaining_r);
        zero_len_s = start && (cycle_count == 32'd0);
        enable_s   = (state_r == RUN) && !start;
    end

    // Window FSM with remaining counter and registered busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            remaining_r <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= last_s | zero_len_s;
            if (start) begin
                if (cycle_count == 32'd0) begin
                    state_r     <= IDLE;
                    remaining_r <= 32'd0;
                    busy_r      <= 1'b0;
                end else begin
                    state_r     <= RUN;
                    remaining_r <= cycle_count;
                    busy_r      <= 1'b1;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r     <= IDLE;
                        remaining_r <= remaining_r;
                        busy_r      <= 1'b0;
                    end
                    RUN: begin
                        if (window_last(remaining_r)) begin
                            state_r     <= IDLE;
                            remaining_r <= 32'd0;
                            busy_r      <= 1'b0;
                        end else begin
                            state_r     <= RUN;
                            remaining_r <= remaining_r - 32'd1;
                            busy_r      <= 1'b1;
                        end
                    end
                    default: begin
                        state_r     <= IDLE;
                        remaining_r <= 32'd0;
                        busy_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        usage_bank #(
            .BYTES_W (BYTES_W),
            .OCC_W   (OCC_W)
        ) u_bank (
            .clk         (clk),
            .reset       (reset),
            .clear       (start),
            .enable      (enable_s),
            .alloc_valid (alloc_valid[b]),
            .alloc_bytes (alloc_bytes[b*BYTES_W +: BYTES_W]),
            .free_valid  (free_valid[b]),
            .free_bytes  (free_bytes[b*BYTES_W +: BYTES_W]),
            .hwm         (hwm_s[b]),
            .underflow   (uflow_s[b])
        );
    end

    assign hwm_0     = hwm_s[0];
    assign hwm_1     = hwm_s[1];
    assign underflow = uflow_s;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_ram_usage_monitor.sv
// Scoreboard bench: a 64-bit and a 17-bit instance share stimulus; a window
// level reference model queues expected results checked on each done pulse.
module tb_ram_usage_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cycle_count = 32'd0;
    logic        start = 1'b0;
    logic [1:0]  alloc_valid = 2'd0;
    logic [31:0] alloc_bytes = 32'd0;
    logic [1:0]  free_valid = 2'd0;
    logic [31:0] free_bytes = 32'd0;

    logic [63:0] hwm_0_a, hwm_1_a;
    logic [16:0] hwm_0_b, hwm_1_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [1:0]  uf_a, uf_b;

    ram_usage_monitor #(.BYTES_W(16), .OCC_W(64)) dut_a (
        .clk(clk), .reset(reset), .cycle_count(cycle_count), .start(start),
        .alloc_valid(alloc_valid), .alloc_bytes(alloc_bytes),
        .free_valid(free_valid), .free_bytes(free_bytes),
        .hwm_0(hwm_0_a), .hwm_1(hwm_1_a), .busy(busy_a), .done(done_a), .underflow(uf_a));

    ram_usage_monitor #(.BYTES_W(16), .OCC_W(17)) dut_b (
        .clk(clk), .reset(reset), .cycle_count(cycle_count), .start(start),
        .alloc_valid(alloc_valid), .alloc_bytes(alloc_bytes),
        .free_valid(free_valid), .free_bytes(free_bytes),
        .hwm_0(hwm_0_b), .hwm_1(hwm_1_b), .busy(busy_b), .done(done_b), .underflow(uf_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        int               busy;
        logic [3:0][63:0] h;
        logic [3:0]       u;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass = 0;

    // Reference model state: [instance][bank], instance 0 = 64-bit, 1 = 17-bit.
    logic [66:0] m_occ [2][2];
    logic [66:0] m_hwm [2][2];
    bit          m_uf  [2][2];
    int          m_left = 0;
    int          m_busy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 2; b++) begin
                m_occ[i][b] = 67'd0;
                m_hwm[i][b] = 67'd0;
                m_uf[i][b]  = 1'b0;
            end
    endtask

    task automatic model_step(input bit st, input int n, input logic [1:0] av,
                              input logic [31:0] ab, input logic [1:0] fv, input logic [31:0] fb);
        bit closing;
        exp_t e;
        closing = 1'b0;
        if (st) begin
            if (m_left == 1) closing = 1'b1;
            model_clear();
            m_left = n;
            if (n == 0) closing = 1'b1;
        end else if (m_left != 0) begin
            for (int i = 0; i < 2; i++)
                for (int b = 0; b < 2; b++) begin
                    logic [66:0] up, dn, capv;
                    capv = (i == 0) ? {3'b000, {64{1'b1}}} : 67'h1FFFF;
                    up = m_occ[i][b] + (av[b] ? 67'(ab[b*16 +: 16]) : 67'd0);
                    dn = fv[b] ? 67'(fb[b*16 +: 16]) : 67'd0;
                    if (dn > up) begin
                        m_occ[i][b] = 67'd0;
                        m_uf[i][b]  = 1'b1;
                    end else if (up - dn > capv) m_occ[i][b] = capv;
                    else m_occ[i][b] = up - dn;
                    if (m_occ[i][b] > m_hwm[i][b]) m_hwm[i][b] = m_occ[i][b];
                end
            m_left--;
            if (m_left == 0) closing = 1'b1;
        end
        if (closing) begin
            e.cyc  = cyc + 1;
            e.busy = m_busy;
            for (int i = 0; i < 2; i++)
                for (int b = 0; b < 2; b++) begin
                    e.h[i*2+b] = m_hwm[i][b][63:0];
                    e.u[i*2+b] = m_uf[i][b];
                end
            q.push_back(e);
            m_busy = 0;
        end
        if (m_left != 0) m_busy++;
    endtask

    task automatic drive(input bit st, input int n, input logic [1:0] av, input logic [31:0] ab,
                         input logic [1:0] fv, input logic [31:0] fb);
        @(posedge clk);
        #1;
        start = st; cycle_count = n; alloc_valid = av; alloc_bytes = ab;
        free_valid = fv; free_bytes = fb;
        model_step(st, n, av, ab, fv, fb);
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 0, 2'd0, 32'd0, 2'd0, 32'd0);
    endtask

    // Monitor: every done pulse retires one expected window result.
    int mon_busy_a = 0;
    int mon_busy_b = 0;
    always @(negedge clk) begin
        if (reset) begin
            mon_busy_a = 0;
            mon_busy_b = 0;
        end else begin
            if (done_a || done_b) begin
                if (q.size() == 0) begin
                    check("spurious_done_a", {63'd0, done_a}, 64'd0);
                    check("spurious_done_b", {63'd0, done_b}, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_a", {63'd0, done_a}, 64'd1);
                    check("done_b", {63'd0, done_b}, 64'd1);
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("busy_cycles_a", 64'(mon_busy_a), 64'(e.busy));
                    check("busy_cycles_b", 64'(mon_busy_b), 64'(e.busy));
                    check("hwm_0_64", hwm_0_a, e.h[0]);
                    check("hwm_1_64", hwm_1_a, e.h[1]);
                    check("hwm_0_17", {47'd0, hwm_0_b}, e.h[2]);
                    check("hwm_1_17", {47'd0, hwm_1_b}, e.h[3]);
                    check("underflow_64", {62'd0, uf_a}, {62'd0, e.u[1:0]});
                    check("underflow_17", {62'd0, uf_b}, {62'd0, e.u[3:2]});
                end
                mon_busy_a = 0;
                mon_busy_b = 0;
            end
            if (busy_a) mon_busy_a++;
            if (busy_b) mon_busy_b++;
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, {62'd0, busy_a, busy_b}, 64'd0);
        check({tag, "_done"}, {62'd0, done_a, done_b}, 64'd0);
        check({tag, "_hwm_a"}, hwm_0_a | hwm_1_a, 64'd0);
        check({tag, "_hwm_b"}, {47'd0, hwm_0_b | hwm_1_b}, 64'd0);
        check({tag, "_uf"}, {60'd0, uf_a, uf_b}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset_state");
        reset = 1'b0;

        // Basic peak tracking on bank 0.
        drive(1'b1, 10, 2'd0, 32'd0, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b01, 32'd100, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b01, 32'd50, 2'd0, 32'd0);
        drive(1'b0, 0, 2'd0, 32'd0, 2'b01, 32'd120);
        idle(12);

        // Zero-length window with allocs on both banks.
        drive(1'b1, 0, 2'b11, {16'd300, 16'd200}, 2'd0, 32'd0);
        idle(4);

        // Simultaneous alloc/free then underflow on bank 1.
        drive(1'b1, 6, 2'd0, 32'd0, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b10, {16'd40, 16'd0}, 2'b10, {16'd10, 16'd0});
        drive(1'b0, 0, 2'd0, 32'd0, 2'b10, {16'd50, 16'd0});
        idle(8);

        // Restart mid-window, then events after the window.
        drive(1'b1, 20, 2'd0, 32'd0, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b01, 32'd500, 2'd0, 32'd0);
        idle(6);
        drive(1'b1, 5, 2'b01, 32'd900, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b01, 32'd7, 2'd0, 32'd0);
        idle(5);
        repeat (4) drive(1'b0, 0, 2'b11, {16'd1000, 16'd1000}, 2'd0, 32'd0);
        idle(2);

        // Saturation of the 17-bit instance.
        drive(1'b1, 5, 2'd0, 32'd0, 2'd0, 32'd0);
        repeat (3) drive(1'b0, 0, 2'b01, 32'h0000_FFFF, 2'd0, 32'd0);
        idle(5);

        // Restart landing on the last window cycle.
        drive(1'b1, 3, 2'd0, 32'd0, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b10, {16'd33, 16'd0}, 2'd0, 32'd0);
        idle(1);
        drive(1'b1, 4, 2'd0, 32'd0, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b01, 32'd11, 2'd0, 32'd0);
        idle(6);

        // Randomized traffic with random starts and window lengths.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ab, fb;
            ab = {16'($urandom_range(0, 3000)), 16'($urandom_range(0, 3000))};
            if ($urandom_range(0, 9) == 0) ab[15:0] = 16'hFFFF;
            fb = {16'($urandom_range(0, 2500)), 16'($urandom_range(0, 2500))};
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 12),
                  2'($urandom_range(0, 3)), ab, 2'($urandom_range(0, 3)), fb);
        end
        idle(16);

        // Asynchronous reset in the middle of a window.
        drive(1'b1, 10, 2'd0, 32'd0, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b11, {16'd77, 16'd66}, 2'd0, 32'd0);
        drive(1'b0, 0, 2'b10, {16'd10, 16'd0}, 2'b01, 32'd500);
        drive(1'b0, 0, 2'd0, 32'd0, 2'd0, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_cleared("async_reset");
        m_left = 0;
        m_busy = 0;
        model_clear();
        #13;
        reset = 1'b0;
        idle(15);

        check("pending_windows", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_usage_monitor.md
Name: ram_usage_monitor

Overview:
- Consumes the control block's `cycle_count` and `start` outputs and produces the `hwm_0` and `hwm_1` high-water marks that block reads back.
- On `start`, clears both banks' occupancy and marks, then runs a measurement window of exactly `cycle_count` clocks.
- During the window it tracks per-bank RAM occupancy from alloc/free byte events and records each bank's peak.

Parameters:
- BYTES_W, 16, width of the per-event alloc/free byte counts.
- OCC_W, 64, width of the occupancy and high-water-mark registers.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cycle_count  input  32  window length in clocks; sampled only when start=1
- start  input  1  one-cycle pulse that begins a new window
- alloc_valid  input  2  per bank: add alloc_bytes this cycle ([0]=bank0, [1]=bank1)
- alloc_bytes  input  2*BYTES_W  per-bank alloc byte count; bank0 in [BYTES_W-1:0]
- free_valid  input  2  per bank: subtract free_bytes this cycle
- free_bytes  input  2*BYTES_W  per-bank free byte count
- hwm_0  output  OCC_W  bank-0 high-water mark
- hwm_1  output  OCC_W  bank-1 high-water mark
- busy  output  1  high while the window is open
- done  output  1  one-cycle pulse when the window closes
- underflow  output  2  sticky per bank; set when a free exceeds occupancy

Behaviour:
- Reset, asynchronous: state=IDLE; remaining=0; occupancy, hwm_0, hwm_1, busy, done and underflow all 0.
- States: IDLE, RUN.
- IDLE:
  - start=1 with cycle_count=N>0: go to RUN; remaining=N; clear occupancy, hwm and underflow for both banks.
  - start=1 with N=0: clear the same registers, stay in IDLE, pulse done on the next cycle.
- Timing for start at cycle T: busy=1 during cycles T+1 .. T+N; events are accepted in exactly those N cycles.
- RUN:
  - Each cycle, remaining decrements.
  - When remaining==1, next state is IDLE and done=1 for one cycle (T+N+1) while busy=0.
- Per-bank update, RUN only:
  - occ_next = occ + (alloc_valid ? alloc_bytes : 0) - (free_valid ? free_bytes : 0), computed at OCC_W+1 bits.
  - Alloc and free in the same cycle are both applied.
  - If the result is negative: occ_next=0 and the bank's underflow bit is set.
  - If the result exceeds 2^OCC_W-1: occ_next saturates to all-ones.
  - hwm <= max(hwm, occ_next), registered in the same cycle as occ, so hwm reflects the event with 1-clock latency.
- Events outside RUN are ignored; occupancy, hwm and underflow hold their values after the window for AXI readback.
- start during RUN restarts the window:
  - Clear the same registers and reload remaining from cycle_count.
  - No done pulse for the aborted window.
  - Events in that start cycle are discarded.
- done and start in the same cycle: the restart wins; done is still pulsed for the completed window.
- Reset asserted mid-window: everything returns to reset values immediately; no done pulse.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, RUN=1.
  - the bank count constant NBANKS=2.
  - BYTES_W and OCC_W defaults.
- One sub-module, `usage_bank`, instantiated twice. It contains:
  - the occupancy register with saturate and underflow logic.
  - the hwm register.
  - a clear input driven by the parent's window-start logic.
- The parent holds the FSM, the remaining counter, busy and done.

Test Plan:
- Basic peak tracking:
  - Stimulus: start with N=10; bank0 alloc 100 in window cycle 1, alloc 50 in cycle 2, free 120 in cycle 3.
  - Required: hwm_0=150, final occ=30, busy high exactly 10 cycles, done one pulse at T+11, hwm_1=0.
- Zero-length window:
  - Stimulus: start with N=0, with alloc asserted on both banks.
  - Required: busy never high, done at T+1, hwm_0=hwm_1=0.
- Simultaneous alloc/free and underflow:
  - Stimulus: bank1 alloc 40 and free 10 in the same cycle (occ=30), then free 50.
  - Required: occ=0, underflow[1]=1 (sticky through the window end), hwm_1=30, underflow[0]=0.
- Restart and window boundaries:
  - Stimulus: start N=20, alloc 500 on bank0, restart with N=5 at window cycle 8, then alloc 7 on bank0.
  - Required: hwm_0=7, exactly one done at restart+6, events after the window ignored.
- Saturation:
  - Stimulus: OCC_W=17 build; alloc 0xFFFF on bank0 three times.
  - Required: occ and hwm_0 saturate at 0x1FFFF, no wrap to a small value.
- Async reset mid-window:
  - Stimulus: assert reset between clock edges during RUN.
  - Required: busy, hwm, underflow and occupancy go to 0 without waiting for an edge; no done pulse after release.
